// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
// Holds the read-mode selector values and the bit positions of the sticky error flags.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  typedef logic [ERR_W-1:0] err_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port WIDTH x DEPTH storage.
// It has one write port and one read port whose output is registered.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // NOTE: the array has no reset, so it can map onto block RAM. Only the
  // read register is reset, which keeps rdata defined after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // NOTE: sequential state always uses <=. A same-edge read of the slot being
  // written therefore returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with internal pointers, exported count, programmable threshold,
// sticky error flags and an optional first-word-fall-through output stage.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = FWFT_OFF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  input  logic [AW:0]      thresh_level,
  output logic             threshold,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic             rd_ok, wr_ok;
  logic [AW:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, count_d, count_q;
  logic             full_d, full_q, empty_d, empty_q, thr_d, thr_q;
  logic             rvalid_d, rvalid_q, byp_sel_d, byp_sel_q;
  logic [WIDTH-1:0] byp_d, byp_q, ram_rdata;
  err_t             err_d, err_q;
  logic             ram_re;
  logic [AW-1:0]    ram_raddr;

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    rd_ok    = ren && !empty_q;
    wr_ok    = wen && (!full_q || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_ok && !rd_ok)      count_d = count_q + PTR_ONE;
    else if (rd_ok && !wr_ok) count_d = count_q - PTR_ONE;

    empty_d = (count_d == '0);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    thr_d   = (count_d >= thresh_level);

    // A new error in the same cycle as clr_err leaves the flag set.
    err_d[ERR_OVF] = (wen && !wr_ok) || (err_q[ERR_OVF] && !clr_err);
    err_d[ERR_UNF] = (ren && !rd_ok) || (err_q[ERR_UNF] && !clr_err);

    rvalid_d = rd_ok;

    // In FWFT mode the RAM prefetches the next head. When that head is being
    // written on the same edge, the RAM returns stale data, so wdata is captured instead.
    byp_sel_d = (FWFT == FWFT_ON) && wr_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
    byp_d     = byp_sel_d ? wdata : byp_q;

    ram_re    = (FWFT == FWFT_ON) ? 1'b1 : rd_ok;
    ram_raddr = (FWFT == FWFT_ON) ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      thr_q     <= 1'b0;
      err_q     <= '0;
      rvalid_q  <= 1'b0;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      thr_q     <= thr_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      byp_sel_q <= byp_sel_d;
      byp_q     <= byp_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (wclk),
    .rst_n (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rdata     = byp_sel_q ? byp_q : ram_rdata;
  assign rvalid    = (FWFT == FWFT_ON) ? !empty_q : rvalid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign threshold = thr_q;
  assign overflow  = err_q[ERR_OVF];
  assign underflow = err_q[ERR_UNF];

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read and an FWFT instance share one
// stimulus stream and are compared against hand-computed values and a queue model.
module tb_fifo_sync_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             wclk = 1'b0;
  logic             rst  = 1'b0;
  logic             wen  = 1'b0;
  logic             ren  = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [AW:0]      thresh_level = 5'd12;

  logic [WIDTH-1:0] s_rdata, f_rdata;
  logic             s_rvalid, f_rvalid, s_full, f_full, s_empty, f_empty;
  logic [AW:0]      s_count, f_count;
  logic             s_thr, f_thr, s_ovf, f_ovf, s_unf, f_unf;

  int total = 0;
  int bad   = 0;

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .wclk(wclk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full), .empty(s_empty),
    .count(s_count), .thresh_level(thresh_level), .threshold(s_thr),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .wclk(wclk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .count(f_count), .thresh_level(thresh_level), .threshold(f_thr),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic emp,
                              input logic ful, input logic thr);
    check({tag, ".std.count"}, 32'(s_count), 32'(cnt));
    check({tag, ".fwft.count"}, 32'(f_count), 32'(cnt));
    check({tag, ".std.empty"}, 32'(s_empty), 32'(emp));
    check({tag, ".fwft.empty"}, 32'(f_empty), 32'(emp));
    check({tag, ".std.full"}, 32'(s_full), 32'(ful));
    check({tag, ".fwft.full"}, 32'(f_full), 32'(ful));
    check({tag, ".std.thr"}, 32'(s_thr), 32'(thr));
    check({tag, ".fwft.thr"}, 32'(f_thr), 32'(thr));
  endtask

  task automatic check_err(input string tag, input logic ovf, input logic unf);
    check({tag, ".std.ovf"}, 32'(s_ovf), 32'(ovf));
    check({tag, ".fwft.ovf"}, 32'(f_ovf), 32'(ovf));
    check({tag, ".std.unf"}, 32'(s_unf), 32'(unf));
    check({tag, ".fwft.unf"}, 32'(f_unf), 32'(unf));
  endtask

  initial begin
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_word;
    logic             m_rd_ok, m_wr_ok;
    int               pw;

    // 1. Reset held for 5 cycles, then released.
    rst = 1'b0;
    repeat (5) step();
    check_status("rst_hold", 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check_status("rst", 0, 1'b1, 1'b0, 1'b0);
    check_err("rst", 1'b0, 1'b0);
    check("rst.std.rvalid", 32'(s_rvalid), 32'd0);
    check("rst.fwft.rvalid", 32'(f_rvalid), 32'd0);
    check("rst.std.rdata", 32'(s_rdata), 32'd0);

    // 2. Fill 0x00..0x0F, then one rejected write.
    wen = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata = 8'(i);
      step();
      check_status("fill", i + 1, 1'b0, (i + 1) == DEPTH, (i + 1) >= 12);
      check("fill.std.rvalid", 32'(s_rvalid), 32'd0);
      check("fill.fwft.rvalid", 32'(f_rvalid), 32'd1);
      check("fill.fwft.head", 32'(f_rdata), 32'h00);
    end
    wdata = 8'hAA;
    step();
    check_status("ovf", 16, 1'b0, 1'b1, 1'b1);
    check_err("ovf", 1'b1, 1'b0);
    wen = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_err("ovf_clr", 1'b0, 1'b0);
    check("ovf_clr.fwft.head", 32'(f_rdata), 32'h00);

    thresh_level = 5'd17;
    step();
    check("thr17.std", 32'(s_thr), 32'd0);
    check("thr17.fwft", 32'(f_thr), 32'd0);
    thresh_level = 5'd12;
    step();
    check("thr12.std", 32'(s_thr), 32'd1);
    check("thr12.fwft", 32'(f_thr), 32'd1);

    // 3. Drain 16 words, then one rejected read.
    ren = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check_status("drain", 15 - i, i == 15, 1'b0, (15 - i) >= 12);
      check("drain.std.rvalid", 32'(s_rvalid), 32'd1);
      check("drain.std.rdata", 32'(s_rdata), 32'(i));
      check("drain.fwft.rvalid", 32'(f_rvalid), 32'(i < 15));
      if (i < 15) check("drain.fwft.head", 32'(f_rdata), 32'(i + 1));
    end
    step();
    check_err("unf", 1'b0, 1'b1);
    check("unf.std.rvalid", 32'(s_rvalid), 32'd0);
    check("unf.std.hold", 32'(s_rdata), 32'h0F);
    check_status("unf", 0, 1'b1, 1'b0, 1'b0);
    ren = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_err("unf_clr", 1'b0, 1'b0);

    // 4. Simultaneous write and read while full, then while empty.
    wen = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata = 8'(8'h10 + i);
      step();
    end
    check_status("refill", 16, 1'b0, 1'b1, 1'b1);
    ren = 1'b1;
    wdata = 8'h55;
    step();
    check_status("simfull", 16, 1'b0, 1'b1, 1'b1);
    check_err("simfull", 1'b0, 1'b0);
    check("simfull.std.rdata", 32'(s_rdata), 32'h10);
    check("simfull.fwft.head", 32'(f_rdata), 32'h11);
    wen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("simdrain.std.rdata", 32'(s_rdata), (i < 15) ? 32'(8'h11 + i) : 32'h55);
    end
    check_status("simdrain", 0, 1'b1, 1'b0, 1'b0);
    wen = 1'b1;
    wdata = 8'h66;
    step();
    check_status("simempty", 1, 1'b0, 1'b0, 1'b0);
    check_err("simempty", 1'b0, 1'b1);
    check("simempty.std.rvalid", 32'(s_rvalid), 32'd0);
    check("simempty.fwft.rvalid", 32'(f_rvalid), 32'd1);
    check("simempty.fwft.head", 32'(f_rdata), 32'h66);
    wen = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    ren = 1'b0;
    check("simpop.std.rdata", 32'(s_rdata), 32'h66);
    check("simpop.std.rvalid", 32'(s_rvalid), 32'd1);
    check_status("simpop", 0, 1'b1, 1'b0, 1'b0);
    check_err("simpop", 1'b0, 1'b0);

    // 5. Random traffic against a queue model; fill/drain bias alternates to force wraps.
    for (int i = 0; i < 1000; i++) begin
      pw    = (((i / 100) % 2) == 0) ? 70 : 30;
      wen   = ($urandom_range(0, 99) < pw);
      ren   = ($urandom_range(0, 99) < (100 - pw));
      wdata = 8'($urandom_range(0, 255));
      check("rnd.fwft.rvalid", 32'(f_rvalid), 32'(q.size() != 0));
      if (q.size() != 0) check("rnd.fwft.head", 32'(f_rdata), 32'(q[0]));
      m_rd_ok  = ren && (q.size() != 0);
      m_wr_ok  = wen && ((q.size() < DEPTH) || m_rd_ok);
      exp_word = '0;
      if (m_rd_ok) exp_word = q.pop_front();
      if (m_wr_ok) q.push_back(wdata);
      step();
      check("rnd.std.count", 32'(s_count), 32'(q.size()));
      check("rnd.fwft.count", 32'(f_count), 32'(q.size()));
      check("rnd.std.rvalid", 32'(s_rvalid), 32'(m_rd_ok));
      if (m_rd_ok) check("rnd.std.rdata", 32'(s_rdata), 32'(exp_word));
    end
    wen = 1'b0;
    ren = 1'b0;

    // 6. Asynchronous reset mid-cycle with 7 words held.
    ren = 1'b1;
    repeat (DEPTH + 1) step();
    ren = 1'b0;
    q.delete();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_status("pre7", 0, 1'b1, 1'b0, 1'b0);
    wen = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wdata = 8'(8'h70 + i);
      step();
    end
    wen = 1'b0;
    check_status("cnt7", 7, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_status("midrst", 0, 1'b1, 1'b0, 1'b0);
    check("midrst.fwft.rvalid", 32'(f_rvalid), 32'd0);
    #3;
    rst = 1'b1;
    ren = 1'b1;
    step();
    ren = 1'b0;
    check_err("postrst", 1'b0, 1'b1);
    check("postrst.std.rvalid", 32'(s_rvalid), 32'd0);
    check_status("postrst", 0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
